// File: rtl/pong_ball.sv
// pong_ball: serve/play/miss ball motion with wall and paddle bounces, updated once per frame.
module pong_ball #(
  parameter int GRAPHICS_WIDTH     = 1280,
  parameter int GRAPHICS_HEIGHT    = 800,
  parameter int BORDER_WIDTH       = 50,
  parameter int BALL_SIZE          = 16,
  parameter int BALL_SPEED         = 4,
  parameter int PADDLE_X           = 110,
  parameter int PADDLE_WIDTH       = 20,
  parameter int PADDLE_LENGTH      = 200,
  parameter int START_X            = 632,
  parameter int START_Y            = 392,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POSITION_REG_MAX   = 11
) (
  input  logic                      pixel_clock,
  input  logic                      reset,
  input  logic                      vga_vertical_sync,
  input  logic [POSITION_REG_MAX:0] h_position,
  input  logic [POSITION_REG_MAX:0] v_position,
  input  logic [POSITION_REG_MAX:0] paddle_y,
  output logic [POSITION_REG_MAX:0] ball_x,
  output logic [POSITION_REG_MAX:0] ball_y,
  output logic                      on_ball,
  output logic                      playing,
  output logic [3:0]                miss_count
);
  localparam int W  = POSITION_REG_MAX + 1;
  localparam int CW = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [W-1:0] SZ  = W'(BALL_SIZE);
  localparam logic [W-1:0] SP  = W'(BALL_SPEED);
  localparam logic [W-1:0] BW  = W'(BORDER_WIDTH);
  localparam logic [W-1:0] BOT = W'(GRAPHICS_HEIGHT - BORDER_WIDTH);
  localparam logic [W-1:0] RGT = W'(GRAPHICS_WIDTH - BORDER_WIDTH);
  localparam logic [W-1:0] PAD = W'(PADDLE_X + PADDLE_WIDTH);
  localparam logic [W-1:0] PL  = W'(PADDLE_LENGTH);
  localparam logic [W-1:0] SX  = W'(START_X);
  localparam logic [W-1:0] SY  = W'(START_Y);
  localparam logic [1:0] SERVE = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] MISS  = 2'd2;

  logic [1:0]   r_state;
  logic [CW-1:0] r_cnt;
  logic         r_serve_dn, r_dx, r_dy, r_last_vsync, r_tick, r_on_ball;
  logic [W-1:0] r_x, r_y;
  logic [3:0]   r_miss;
  logic         w_hit, w_miss, w_rclamp, w_tclamp, w_bclamp, w_ndx, w_ndy, w_on;
  logic [W-1:0] w_nx, w_ny;

  // dx=1 is right, dy=1 is down; all compares are on sums so nothing underflows
  always_comb begin
    w_hit    = !r_dx && r_x >= PAD && r_x < PAD + SP && r_y + SZ > paddle_y && r_y < paddle_y + PL;
    w_miss   = !r_dx && !w_hit && r_x < BW + SP;
    w_rclamp = r_dx && r_x + SZ + SP > RGT;
    w_tclamp = !r_dy && r_y < BW + SP;
    w_bclamp = r_dy && r_y + SZ + SP > BOT;
    w_nx     = r_dx ? (w_rclamp ? RGT - SZ : r_x + SP) : (w_hit ? PAD : r_x - SP);
    w_ndx    = r_dx ? !w_rclamp : w_hit;
    w_ny     = r_dy ? (w_bclamp ? BOT - SZ : r_y + SP) : (w_tclamp ? BW : r_y - SP);
    w_ndy    = r_dy ? !w_bclamp : w_tclamp;
    w_on     = h_position >= r_x && h_position < r_x + SZ && v_position >= r_y && v_position < r_y + SZ;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_state      <= SERVE;
      r_cnt        <= '0;
      r_serve_dn   <= 1'b1;
      r_x          <= SX;
      r_y          <= SY;
      r_dx         <= 1'b0;
      r_dy         <= 1'b1;
      r_on_ball    <= 1'b0;
      r_miss       <= 4'd0;
      r_last_vsync <= 1'b1;
      r_tick       <= 1'b0;
    end else begin
      r_last_vsync <= vga_vertical_sync;
      r_tick       <= vga_vertical_sync & ~r_last_vsync;
      r_on_ball    <= w_on;
      if (r_state == MISS) begin
        r_miss  <= (r_miss == 4'hF) ? r_miss : r_miss + 4'd1;
        r_x     <= SX;
        r_y     <= SY;
        r_cnt   <= '0;
        r_state <= SERVE;
      end else if (r_tick) begin
        if (r_state == SERVE) begin
          r_x <= SX;
          r_y <= SY;
          if (r_cnt == CW'(SERVE_DELAY_FRAMES - 1)) begin
            r_state    <= PLAY;
            r_cnt      <= '0;
            r_dx       <= 1'b0;
            r_dy       <= r_serve_dn;
            r_serve_dn <= ~r_serve_dn;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (r_state == PLAY) begin
          if (w_miss) begin
            r_state <= MISS;
          end else begin
            r_x  <= w_nx;
            r_dx <= w_ndx;
            r_y  <= w_ny;
            r_dy <= w_ndy;
          end
        end else begin
          r_state <= SERVE;
        end
      end
    end
  end

  assign ball_x     = r_x;
  assign ball_y     = r_y;
  assign on_ball    = r_on_ball;
  assign playing    = r_state == PLAY;
  assign miss_count = r_miss;
endmodule

// File: doc/pong_ball.md
PONG_BALL -- requirements
Module: pong_ball

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- GRAPHICS_WIDTH, 1280, visible width
- GRAPHICS_HEIGHT, 800, visible height
- BORDER_WIDTH, 50, border thickness
- BALL_SIZE, 16, ball edge length
- BALL_SPEED, 4, pixels per tick per axis
- PADDLE_X, 110, paddle left edge
- PADDLE_WIDTH, 20, paddle width
- PADDLE_LENGTH, 200, paddle height
- START_X, 632, serve x
- START_Y, 392, serve y
- SERVE_DELAY_FRAMES, 60, ticks held before play
- POSITION_REG_MAX, 11, MSB of position buses

REQ-002 Ports SHALL be (name, direction, width, meaning):
- pixel_clock, in, 1, sole clock
- reset, in, 1, synchronous active-high reset
- vga_vertical_sync, in, 1, frame sync from the VGA timing generator
- h_position, in, 12, current pixel column
- v_position, in, 12, current pixel row
- paddle_y, in, 12, paddle top edge
- ball_x, out, 12, ball left edge
- ball_y, out, 12, ball top edge
- on_ball, out, 1, registered pixel-in-ball flag
- playing, out, 1, high in PLAY
- miss_count, out, 4, saturating miss counter

REQ-003 There SHALL be one clock and one reset; reset is synchronous and active-high, named pixel_clock and reset.

Function
REQ-004 Tick: one cycle after each 0->1 edge of vga_vertical_sync, detected against a registered copy (last_vsync).
REQ-005 States SHALL be SERVE, PLAY, MISS; all position and state updates happen only on tick cycles.
REQ-006 SERVE: ball held at START_X/START_Y; serve counter increments per tick; on the tick where counter == SERVE_DELAY_FRAMES-1, go to PLAY, clear counter, set dx=left, and take dy from the serve-direction bit, which then toggles.
REQ-007 PLAY per tick: x -= / += BALL_SPEED per dx; y -= / += BALL_SPEED per dy; X and Y rules are evaluated independently in the same tick.
REQ-008 Top: dy=up and ball_y < BORDER_WIDTH+BALL_SPEED -> ball_y = BORDER_WIDTH, dy = down.
REQ-009 Bottom: dy=down and ball_y+BALL_SIZE+BALL_SPEED > GRAPHICS_HEIGHT-BORDER_WIDTH -> ball_y = GRAPHICS_HEIGHT-BORDER_WIDTH-BALL_SIZE, dy = up.
REQ-010 Right: dx=right and ball_x+BALL_SIZE+BALL_SPEED > GRAPHICS_WIDTH-BORDER_WIDTH -> ball_x = GRAPHICS_WIDTH-BORDER_WIDTH-BALL_SIZE, dx = left.
REQ-011 Paddle hit, which takes priority over a miss:
- Condition: dx=left, ball_x >= PADDLE_X+PADDLE_WIDTH, ball_x < PADDLE_X+PADDLE_WIDTH+BALL_SPEED, ball_y+BALL_SIZE > paddle_y and ball_y < paddle_y+PADDLE_LENGTH.
- Action: ball_x = PADDLE_X+PADDLE_WIDTH, dx = right.
REQ-012 Miss: dx=left, no paddle hit and ball_x < BORDER_WIDTH+BALL_SPEED -> MISS; position is not updated on that tick.
REQ-013 MISS lasts exactly one cycle:
- miss_count increments and saturates at 15.
- ball reloads START_X/START_Y and the serve counter clears.
- next state is SERVE.
REQ-014 All arithmetic SHALL be done 12 bits wide, unsigned, comparing sums rather than differences so nothing underflows.
REQ-015 on_ball is registered. It is 1 one cycle after h_position in [ball_x, ball_x+BALL_SIZE) and v_position in [ball_y, ball_y+BALL_SIZE); otherwise 0.
REQ-016 playing SHALL be 1 exactly while the state is PLAY.

Reset
REQ-017 Reset SHALL set:
- state to SERVE
- serve counter to 0 and serve-direction to down
- ball_x to START_X and ball_y to START_Y
- dx to left and dy to down
- on_ball to 0 and miss_count to 0
- last_vsync to 1, so no tick is produced on release
REQ-018 Reset asserted in any state SHALL take effect on the next clock edge and override a coincident tick.

Verification
REQ-019 Serve: reset, then 60 vsync rising edges -> playing=1 after 60th tick; next tick ball_x=628, ball_y=396 (dy=down first serve).
REQ-020 on_ball during SERVE: h=632,v=392 -> on_ball=1 next cycle; h=648,v=392 -> 0; h=631 -> 0.
REQ-021 Miss: paddle_y=600, play until ball_x <54 on left travel -> one-cycle MISS, miss_count=1, ball_x=632, ball_y=392, playing=0; second serve dy=up.
REQ-022 Paddle hit: paddle_y tracking ball_y-50 -> ball_x clamps to 130, dx flips right, miss_count unchanged; later right wall clamps ball_x=1214.
REQ-023 Walls and saturation: run 16+ misses -> miss_count holds 15; observe top clamp ball_y=50 and bottom clamp ball_y=734 with dy flips.
REQ-024 Reset mid-PLAY coincident with a tick -> next cycle state SERVE, ball at 632/392, miss_count=0, no position step applied.
